// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-back data cache: width derivation,
// miss-handling FSM states and bit-PLRU victim/update rules.
package dcache_pkg;

  localparam int unsigned MAX_WAYS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_WB,
    S_RD_REQ,
    S_FILL
  } state_t;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned baddr_w, input int unsigned sets);
    return baddr_w - $clog2(sets);
  endfunction

  function automatic int unsigned block_w(input int unsigned block_bytes);
    return 8 * block_bytes;
  endfunction

  // Lowest invalid way first, otherwise lowest way whose MRU bit is clear.
  function automatic logic [MAX_WAYS-1:0] plru_victim(input logic [MAX_WAYS-1:0] valid,
                                                      input logic [MAX_WAYS-1:0] mru,
                                                      input int unsigned ways);
    logic [MAX_WAYS-1:0] sel;
    logic                found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (i < ways && !found && !valid[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (i < ways && !found && !mru[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!found) sel[0] = 1'b1;
    return sel;
  endfunction

  function automatic logic [MAX_WAYS-1:0] plru_update(input logic [MAX_WAYS-1:0] mru,
                                                      input logic [MAX_WAYS-1:0] way_oh,
                                                      input int unsigned ways);
    logic [MAX_WAYS-1:0] full;
    logic [MAX_WAYS-1:0] upd;
    full = '0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (i < ways) full[i] = 1'b1;
    end
    upd = mru | way_oh;
    if (upd == full) upd = way_oh;
    return upd;
  endfunction

endpackage

// File: rtl/dcache_tag_way_sel.sv
// Per-set tag compare: produces the hit vector and the one-hot PLRU victim.
module dcache_tag_way_sel
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 22
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [WAYS-1:0][TAG_W-1:0]  set_tags,
  input  logic [WAYS-1:0]             set_valid,
  input  logic [WAYS-1:0]             set_mru,
  output logic [WAYS-1:0]             hit_vec,
  output logic                        hit,
  output logic [WAYS-1:0]             victim_oh
);

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      hit_vec[i] = set_valid[i] && (set_tags[i] == tag);
    end
    hit = |hit_vec;
  end

  always_comb begin
    victim_oh = WAYS'(plru_victim(MAX_WAYS'(set_valid), MAX_WAYS'(set_mru), WAYS));
  end

endmodule

// File: rtl/dcache_wb_array.sv
// N-way set-associative write-back data cache with an internal miss FSM
// (victim writeback, refill request, fill) behind a request/response port.
module dcache_wb_array
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 64,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned BADDR_W     = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic                       cpu_req_we,
  input  logic [BADDR_W-1:0]         cpu_req_baddr,
  input  logic [BLOCK_BYTES-1:0]     cpu_req_be,
  input  logic [8*BLOCK_BYTES-1:0]   cpu_req_wdata,
  output logic                       cpu_resp_valid,
  output logic [8*BLOCK_BYTES-1:0]   cpu_resp_rdata,
  output logic                       cpu_resp_hit,
  output logic                       mem_wb_valid,
  input  logic                       mem_wb_ready,
  output logic [BADDR_W-1:0]         mem_wb_baddr,
  output logic [8*BLOCK_BYTES-1:0]   mem_wb_data,
  output logic                       mem_rd_valid,
  input  logic                       mem_rd_ready,
  output logic [BADDR_W-1:0]         mem_rd_baddr,
  input  logic                       mem_fill_valid,
  input  logic [8*BLOCK_BYTES-1:0]   mem_fill_data
);

  localparam int unsigned IDX_W   = idx_w(SETS);
  localparam int unsigned TAG_W   = tag_w(BADDR_W, SETS);
  localparam int unsigned BLOCK_W = block_w(BLOCK_BYTES);
  localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t state, state_next;

  logic                   req_we;
  logic [BADDR_W-1:0]     req_baddr;
  logic [BLOCK_BYTES-1:0] req_be;
  logic [BLOCK_W-1:0]     req_wdata;
  logic                   miss;
  logic [WAY_W-1:0]       victim_way;

  logic [TAG_W-1:0]   tag_arr   [SETS][WAYS];
  logic [BLOCK_W-1:0] data_arr  [SETS][WAYS];
  logic [WAYS-1:0]    valid_arr [SETS];
  logic [WAYS-1:0]    dirty_arr [SETS];
  logic [WAYS-1:0]    mru_arr   [SETS];

  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            tag;
  logic [WAYS-1:0][TAG_W-1:0]  set_tags;
  logic [WAYS-1:0]             hit_vec;
  logic [WAYS-1:0]             victim_oh;
  logic                        hit;
  logic [WAY_W-1:0]            hit_way;
  logic [WAY_W-1:0]            vict_sel;
  logic [BLOCK_W-1:0]          merged;
  logic [WAYS-1:0]             mru_next;

  assign idx = req_baddr[IDX_W-1:0];
  assign tag = req_baddr[BADDR_W-1:IDX_W];

  always_comb begin
    set_tags = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      set_tags[i] = tag_arr[idx][i];
    end
  end

  dcache_tag_way_sel #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W)
  ) u_way_sel (
    .tag       (tag),
    .set_tags  (set_tags),
    .set_valid (valid_arr[idx]),
    .set_mru   (mru_arr[idx]),
    .hit_vec   (hit_vec),
    .hit       (hit),
    .victim_oh (victim_oh)
  );

  always_comb begin
    hit_way  = '0;
    vict_sel = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit_vec[i])   hit_way  = WAY_W'(i);
      if (victim_oh[i]) vict_sel = WAY_W'(i);
    end
  end

  always_comb begin
    merged = data_arr[idx][hit_way];
    for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
      if (req_we && req_be[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
    end
    mru_next = WAYS'(plru_update(MAX_WAYS'(mru_arr[idx]), MAX_WAYS'(hit_vec), WAYS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (cpu_req_valid) state_next = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)
          state_next = S_RESP;
        else if (valid_arr[idx][vict_sel] && dirty_arr[idx][vict_sel])
          state_next = S_WB;
        else
          state_next = S_RD_REQ;
      end
      S_RESP:   state_next = S_IDLE;
      S_WB:     if (mem_wb_ready)   state_next = S_RD_REQ;
      S_RD_REQ: if (mem_rd_ready)   state_next = S_FILL;
      S_FILL:   if (mem_fill_valid) state_next = S_LOOKUP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Memory-side outputs are gated by state so reset clears them asynchronously.
  assign cpu_req_ready = (state == S_IDLE);
  assign mem_wb_valid  = (state == S_WB);
  assign mem_wb_baddr  = mem_wb_valid ? {tag_arr[idx][victim_way], idx} : '0;
  assign mem_wb_data   = mem_wb_valid ? data_arr[idx][victim_way] : '0;
  assign mem_rd_valid  = (state == S_RD_REQ);
  assign mem_rd_baddr  = mem_rd_valid ? req_baddr : '0;

  // The response pulse is registered out of RESP, giving hit latency accept+2 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we         <= 1'b0;
      req_baddr      <= '0;
      req_be         <= '0;
      req_wdata      <= '0;
      miss           <= 1'b0;
      victim_way     <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_hit   <= 1'b0;
      cpu_resp_rdata <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        mru_arr[s]   <= '0;
      end
    end else begin
      cpu_resp_valid <= (state == S_RESP);
      cpu_resp_hit   <= (state == S_RESP) && !miss;
      unique case (state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            req_we    <= cpu_req_we;
            req_baddr <= cpu_req_baddr;
            req_be    <= cpu_req_be;
            req_wdata <= cpu_req_wdata;
            miss      <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            mru_arr[idx]   <= mru_next;
            cpu_resp_rdata <= merged;
            if (req_we) dirty_arr[idx][hit_way] <= 1'b1;
          end else begin
            miss       <= 1'b1;
            victim_way <= vict_sel;
          end
        end
        S_WB: begin
          if (mem_wb_ready) dirty_arr[idx][victim_way] <= 1'b0;
        end
        S_FILL: begin
          if (mem_fill_valid) begin
            valid_arr[idx][victim_way] <= 1'b1;
            dirty_arr[idx][victim_way] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_we) begin
      data_arr[idx][hit_way] <= merged;
    end
    if (state == S_FILL && mem_fill_valid) begin
      data_arr[idx][victim_way] <= mem_fill_data;
      tag_arr[idx][victim_way]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb_array.sv
// Bench for dcache_wb_array: directed scenarios plus random traffic compared
// against a behavioural cache/memory model.
module tb_dcache_wb_array;

  localparam int WAYS = 2;
  localparam int SETS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [7:0]  cpu_req_baddr = '0;
  logic [3:0]  cpu_req_be = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_hit;
  logic        mem_wb_valid;
  logic        mem_wb_ready = 1'b0;
  logic [7:0]  mem_wb_baddr;
  logic [31:0] mem_wb_data;
  logic        mem_rd_valid;
  logic        mem_rd_ready = 1'b0;
  logic [7:0]  mem_rd_baddr;
  logic        mem_fill_valid = 1'b0;
  logic [31:0] mem_fill_data = '0;

  always #5 clk = ~clk;

  dcache_wb_array #(
    .WAYS        (2),
    .SETS        (4),
    .BLOCK_BYTES (4),
    .BADDR_W     (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_baddr  (cpu_req_baddr),
    .cpu_req_be     (cpu_req_be),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_hit   (cpu_resp_hit),
    .mem_wb_valid   (mem_wb_valid),
    .mem_wb_ready   (mem_wb_ready),
    .mem_wb_baddr   (mem_wb_baddr),
    .mem_wb_data    (mem_wb_data),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_ready   (mem_rd_ready),
    .mem_rd_baddr   (mem_rd_baddr),
    .mem_fill_valid (mem_fill_valid),
    .mem_fill_data  (mem_fill_data)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference state: cache lines plus a flat backing memory.
  logic        m_valid [SETS][WAYS];
  logic        m_dirty [SETS][WAYS];
  logic        m_mru   [SETS][WAYS];
  logic [5:0]  m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  logic [31:0] mem     [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_mru[s][w]   = 1'b0;
      end
    end
  endtask

  task automatic model_access(input logic we, input logic [7:0] a, input logic [3:0] be,
                              input logic [31:0] wd, output logic hit, output logic wb,
                              output logic [7:0] wb_addr, output logic [31:0] wb_data,
                              output logic [31:0] rdata);
    logic [1:0] s;
    logic [5:0] t;
    int         way;
    bit         all_set;
    s = a[1:0];
    t = a[7:2];
    way = -1;
    wb = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    hit = (way >= 0);
    if (!hit) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_mru[s][w]) way = w;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) way = 0;
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1'b1;
        wb_addr = {m_tag[s][way], s};
        wb_data = m_data[s][way];
        mem[wb_addr] = wb_data;
      end
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way]   = t;
      m_data[s][way]  = mem[a];
    end
    m_mru[s][way] = 1'b1;
    all_set = 1'b1;
    for (int w = 0; w < WAYS; w++) all_set = all_set & m_mru[s][w];
    if (all_set) for (int w = 0; w < WAYS; w++) m_mru[s][w] = (w == way);
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_data[s][way][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][way] = 1'b1;
    end
    rdata = m_data[s][way];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic access(input logic we, input logic [7:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int dly, input bit hold, input bit abort,
                        output logic obs_hit, output logic [31:0] obs_rdata);
    logic        e_hit, e_wb;
    logic [7:0]  e_wb_addr, wb_addr0, rd_addr0;
    logic [31:0] e_wb_data, e_rdata, wb_data0;
    bit saw_wb = 0, saw_rd = 0, rd_hs = 0, in_fill = 0, fill_sent = 0, got_resp = 0;
    bit busy_ready = 0, wb_unstable = 0, rd_early = 0;
    int cyc = 0, wb_cnt = 0, rd_cnt = 0, fill_cnt = 0;
    obs_hit = 1'bx;
    obs_rdata = 'x;
    wb_addr0 = '0;
    wb_data0 = '0;
    rd_addr0 = '0;
    model_access(we, a, be, wd, e_hit, e_wb, e_wb_addr, e_wb_data, e_rdata);
    chk("ready_in_idle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_baddr = a;
    cpu_req_be    = be;
    cpu_req_wdata = wd;
    @(negedge clk);
    if (!hold) cpu_req_valid = 1'b0;
    while (!got_resp && cyc < 200) begin
      cyc++;
      mem_fill_valid = 1'b0;
      if (rd_hs) in_fill = 1;
      if (cpu_resp_valid) begin
        got_resp = 1;
      end else begin
        if (cpu_req_ready) busy_ready = 1;
        if (in_fill && !fill_sent) begin
          if (abort) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_rd_valid", mem_rd_valid, 0);
            chk("rst_wb_valid", mem_wb_valid, 0);
            chk("rst_resp_valid", cpu_resp_valid, 0);
            chk("rst_resp_rdata", cpu_resp_rdata, 0);
            chk("rst_req_ready", cpu_req_ready, 1);
            cpu_req_valid = 1'b0;
            mem_rd_ready  = 1'b0;
            mem_wb_ready  = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            @(negedge clk);
            chk("ready_after_rst", cpu_req_ready, 1);
            return;
          end
          if (fill_cnt >= dly) begin
            mem_fill_valid = 1'b1;
            mem_fill_data  = mem[a];
            fill_sent = 1;
          end else fill_cnt++;
        end
        if (mem_wb_valid) begin
          if (!saw_wb) begin
            saw_wb = 1;
            wb_addr0 = mem_wb_baddr;
            wb_data0 = mem_wb_data;
          end else if (mem_wb_baddr !== wb_addr0 || mem_wb_data !== wb_data0) wb_unstable = 1;
          if (wb_cnt >= dly) mem_wb_ready = 1'b1;
          else begin
            mem_wb_ready = 1'b0;
            wb_cnt++;
          end
        end else mem_wb_ready = 1'b0;
        if (mem_rd_valid) begin
          if (!saw_rd) rd_addr0 = mem_rd_baddr;
          if (e_wb && !saw_wb) rd_early = 1;
          saw_rd = 1;
          if (rd_cnt >= dly) begin
            mem_rd_ready = 1'b1;
            rd_hs = 1;
          end else rd_cnt++;
        end else mem_rd_ready = 1'b0;
        @(negedge clk);
      end
    end
    cpu_req_valid = 1'b0;
    mem_wb_ready  = 1'b0;
    mem_rd_ready  = 1'b0;
    mem_fill_valid = 1'b0;
    chk("resp_seen", got_resp, 1);
    obs_hit   = cpu_resp_hit;
    obs_rdata = cpu_resp_rdata;
    chk("resp_hit", cpu_resp_hit, e_hit);
    chk("resp_rdata", cpu_resp_rdata, e_rdata);
    chk("wb_seen", saw_wb, e_wb);
    if (e_wb) begin
      chk("wb_baddr", wb_addr0, e_wb_addr);
      chk("wb_data", wb_data0, e_wb_data);
      chk("wb_stable", wb_unstable, 0);
    end
    chk("rd_seen", saw_rd, !e_hit);
    if (saw_rd) chk("rd_baddr", rd_addr0, a);
    chk("rd_after_wb", rd_early, 0);
    chk("no_accept_busy", busy_ready, 0);
    if (e_hit) chk("hit_latency", cyc, 3);
    @(negedge clk);
    chk("resp_one_cycle", cpu_resp_valid, 0);
  endtask

  initial begin
    logic        h;
    logic [31:0] d, d_keep;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h05] = 32'hDEADBEEF;
    model_reset();

    @(negedge clk);
    chk("reset_ready", cpu_req_ready, 1);
    chk("reset_resp_valid", cpu_resp_valid, 0);
    chk("reset_resp_rdata", cpu_resp_rdata, 0);
    chk("reset_wb_valid", mem_wb_valid, 0);
    chk("reset_rd_valid", mem_rd_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss then hit.
    access(1'b0, 8'h05, 4'h0, 32'h0, 1, 0, 0, h, d);
    chk("cold_rdata", d, 32'hDEADBEEF);
    chk("cold_hit", h, 0);
    access(1'b0, 8'h05, 4'h0, 32'h0, 0, 0, 0, h, d);
    chk("reread_hit", h, 1);

    // Partial write hit.
    access(1'b1, 8'h05, 4'b0011, 32'h00001234, 0, 0, 0, h, d);
    chk("write_rdata", d, 32'hDEAD1234);
    chk("write_hit", h, 1);

    // PLRU eviction of a clean line.
    access(1'b0, 8'h09, 4'h0, 32'h0, 0, 0, 0, h, d);
    access(1'b0, 8'h05, 4'h0, 32'h0, 0, 0, 0, h, d);
    access(1'b0, 8'h0D, 4'h0, 32'h0, 2, 0, 0, h, d);
    chk("evict_clean_hit", h, 0);

    // Dirty eviction with a stalled writeback.
    access(1'b0, 8'h11, 4'h0, 32'h0, 3, 0, 0, h, d);
    chk("dirty_evict_hit", h, 0);
    chk("dirty_wb_mem", mem[8'h05], 32'hDEAD1234);

    // Reset while waiting for fill, then cold miss again.
    access(1'b0, 8'h19, 4'h0, 32'h0, 1, 0, 1, h, d);
    access(1'b0, 8'h05, 4'h0, 32'h0, 0, 0, 0, h, d);
    chk("post_rst_miss", h, 0);

    // Held request during a miss, then a stray fill in IDLE.
    access(1'b0, 8'h22, 4'h0, 32'h0, 2, 1, 0, h, d_keep);
    mem_fill_valid = 1'b1;
    mem_fill_data  = ~d_keep;
    @(negedge clk);
    mem_fill_valid = 1'b0;
    @(negedge clk);
    access(1'b0, 8'h22, 4'h0, 32'h0, 0, 0, 0, h, d);
    chk("stray_fill_hit", h, 1);
    chk("stray_fill_data", d, d_keep);

    for (int n = 0; n < 200; n++) begin
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 4'($urandom),
             $urandom, int'($urandom_range(0, 2)), 0, 0, h, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dcache_wb_array.md
Name: dcache_wb_array

Overview:
- Parametrised N-way set-associative write-back data cache: tag/data/valid/dirty/MRU arrays plus its own miss-handling FSM.
- Sits between the MEM-stage block-level access port and main memory.
- Handles the full miss sequence internally: victim selection, dirty writeback and refill, each over valid/ready handshakes.
- The pipeline only sees a request/response pair.

Parameters:
- WAYS, 2, associativity (>=1); 1 gives a direct-mapped cache.
- SETS, 64, number of sets (power of 2, >=2); IDX_W = log2(SETS).
- BLOCK_BYTES, 16, bytes per block; BLOCK_W = 8*BLOCK_BYTES.
- BADDR_W, 28, block-address width; TAG_W = BADDR_W - IDX_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  access request.
- cpu_req_ready  out  1  high only in IDLE.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_baddr  in  BADDR_W  {tag, index}; index = low IDX_W bits.
- cpu_req_be  in  BLOCK_BYTES  byte enables for writes.
- cpu_req_wdata  in  BLOCK_W  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  BLOCK_W  block contents after the access.
- cpu_resp_hit  out  1  1 if the request completed with no miss.
- mem_wb_valid  out  1  writeback request.
- mem_wb_ready  in  1  writeback accept.
- mem_wb_baddr  out  BADDR_W  victim block address.
- mem_wb_data  out  BLOCK_W  victim data.
- mem_rd_valid  out  1  refill request.
- mem_rd_ready  in  1  refill request accept.
- mem_rd_baddr  out  BADDR_W  refill block address.
- mem_fill_valid  in  1  refill data strobe.
- mem_fill_data  in  BLOCK_W  refill data.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - FSM goes to IDLE.
  - All valid, dirty and MRU bits cleared.
  - All outputs 0 except cpu_req_ready=1; cpu_resp_rdata=0.
  - Tag and data arrays are not reset.
  - Reset mid-operation abandons the request and drops any mem_* valid immediately (asynchronously).
- States: IDLE, LOOKUP, RESP, WB, RD_REQ, FILL.
- IDLE:
  - ready=1.
  - On valid&ready, latch we/baddr/be/wdata, clear the miss flag, go to LOOKUP.
  - Requests in any other state are ignored; the requester must hold them.
- LOOKUP:
  - Combinational compare of the latched tag across all ways of the set; hit = valid & tag match.
  - On hit:
    - At the clock edge, update MRU.
    - If we: write only the enabled bytes and set dirty.
    - Capture the resulting block into cpu_resp_rdata; go to RESP.
  - On miss:
    - Set the miss flag, register the victim way.
    - Go to WB if victim valid&dirty, else RD_REQ.
- RESP: cpu_resp_valid=1 for exactly one cycle; cpu_resp_hit = !miss flag; go to IDLE.
- Hit latency: accept at edge N, cpu_resp_valid high during the cycle after edge N+2.
- WB:
  - mem_wb_valid=1, with mem_wb_baddr = {victim tag, index} and mem_wb_data = victim data, all held stable until mem_wb_ready.
  - On handshake, clear the victim's dirty bit and go to RD_REQ.
- RD_REQ: mem_rd_valid=1, mem_rd_baddr = latched baddr, held until mem_rd_ready; then go to FILL.
- FILL:
  - Wait for mem_fill_valid, which is ignored in every other state.
  - On mem_fill_valid: write data/tag to the victim way, set valid=1, dirty=0; MRU untouched.
  - Return to LOOKUP, which now hits and completes the read/write (merging write bytes into the fill).
- Victim selection:
  - Lowest-index invalid way.
  - If all ways are valid: lowest-index way with MRU=0.
- MRU (bit-PLRU):
  - On hit to way i, set MRU[i].
  - If that would make every bit of the set 1, clear all bits except i.
  - WAYS=1: victim is always way 0; MRU is unused.
- Same-cycle mem_wb_ready/mem_rd_ready with valid low has no effect.
- Single outstanding miss; no hit-under-miss.

Decomposition:
- Shared package dcache_pkg:
  - Derived widths IDX_W, TAG_W, BLOCK_W.
  - FSM state enum.
  - Function plru_victim(valid, mru) returning a one-hot way.
  - Function plru_update(mru, way).
- One natural sub-module, dcache_tag_way_sel: combinational tag compare, hit vector and victim one-hot for one set.
- The FSM and arrays stay in dcache_wb_array.

Test Plan:
Bench configuration: WAYS=2, SETS=4, BLOCK_BYTES=4, BADDR_W=8.
1. Cold read 0x05 after reset:
   - mem_wb_valid stays 0; mem_rd_baddr=0x05.
   - Fill 0xDEADBEEF -> resp rdata=0xDEADBEEF, hit=0.
   - Re-read 0x05 -> hit=1, resp exactly 2 cycles after accept, no mem traffic.
2. Write 0x05, be=4'b0011, wdata=0x00001234 -> resp rdata=0xDEAD1234, hit=1; the line is now dirty.
3. PLRU eviction:
   - Fill 0x09, then read 0x05; MRU ends at {w1=0, w0=1}.
   - Read 0x0D -> victim way1 (0x09), clean, so no writeback; mem_rd_baddr=0x0D.
4. Dirty eviction:
   - Make 0x05 LRU, then read 0x11 -> mem_wb_valid with baddr=0x05, data=0xDEAD1234.
   - Hold mem_wb_ready=0 for 3 cycles -> valid/baddr/data stable; refill only starts after the handshake.
5. Async reset during FILL:
   - All outputs drop immediately; cpu_req_ready=1 after release.
   - Read 0x05 -> miss with no writeback.
6. Stray and held traffic:
   - cpu_req_valid held during a miss is not accepted until IDLE.
   - A mem_fill_valid pulse in IDLE changes no array state (next read of the same address still hits with the old data).
